ql_step_scheduler: RTL and testbench
====================================

Name: ql_step_scheduler

Overview:
Top-level sequencer for the Q-learning agent. It performs a handshake with the environment for each observation (state, reward, terminal) and pulses the Q-update accelerator with the previous (state, action) pair. It then triggers the policy generator and returns the chosen action to the environment. It also counts steps and episodes and owns the per-episode epsilon decay schedule fed to the policy generator.

Parameters:
STATE_W, 6, state index width
ACTION_W, 4, action index width
REWARD_W, 16, reward width (signed fixed-point, passed through)
EPS_W, 16, epsilon width (unsigned, 0xFFFF ~ 1.0)
UPDATE_LAT, 3, cycles the accelerator needs after acc_en before its table is consistent
MAX_STEPS, 255, step limit per episode (forced episode end)
EPS_SHIFT, 4, decay: eps -= eps >> EPS_SHIFT per episode
EPS_MIN, 16'h0100, epsilon floor

Ports:
clk in 1 clock, rising edge
rst_n in 1 async active-low reset
start in 1 pulse; begins training run when idle
num_episodes in 16 episodes to run, sampled on accepted start
eps_init in EPS_W initial epsilon, sampled on accepted start
obs_valid in 1 environment observation valid
obs_ready out 1 scheduler accepts observation
obs_state in STATE_W observed state
obs_reward in REWARD_W reward for previous action
obs_terminal in 1 observed state is terminal
act_valid out 1 action valid to environment
act_ready in 1 environment accepts action
act_out out ACTION_W action to environment
acc_en out 1 one-cycle Q-update strobe
acc_curr_state out STATE_W previous state
acc_curr_action out ACTION_W previous action
acc_next_state out STATE_W newly observed state
acc_reward out REWARD_W captured reward
pol_start out 1 one-cycle policy request
pol_state out STATE_W state for policy lookup
pol_done in 1 policy result valid (single cycle)
pol_action in ACTION_W policy result
epsilon out EPS_W current epsilon
busy out 1 run in progress
done out 1 one-cycle pulse at end of run
episode_cnt out 16 completed episodes
step_cnt out 8 steps in current episode
err out 1 sticky policy timeout flag (feature only, else tied 0)

Behaviour:
- Reset: FSM=IDLE; all outputs 0, including epsilon, counters and err; internal first_step=1.
- FSM states: IDLE, WAIT_OBS, UPDATE, WAIT_LAT, POLICY, WAIT_POL, ISSUE, EP_END, FINISH.
- IDLE:
  - start=1 latches num_episodes and eps_init, zeroes counters and sets busy=1.
  - num_episodes==0 goes to FINISH; otherwise goes to WAIT_OBS.
  - start is ignored in every other state.
- WAIT_OBS:
  - obs_ready=1. Transfer occurs on obs_valid&&obs_ready; capture state, reward and terminal.
  - If first_step=1 the update is skipped: go to POLICY if not terminal, else EP_END. Otherwise go to UPDATE.
- UPDATE: acc_en=1 for exactly one cycle with the acc_* operands stable, then WAIT_LAT.
- WAIT_LAT:
  - Hold for UPDATE_LAT cycles.
  - Then go to EP_END if terminal or step_cnt==MAX_STEPS; else POLICY.
- POLICY: pol_start=1 for one cycle with pol_state=captured state, then WAIT_POL.
- WAIT_POL: on pol_done, register pol_action and go to ISSUE.
- ISSUE:
  - act_valid=1 with act_out stable until act_ready.
  - On handshake: prev_state<=captured state, prev_action<=act_out, step_cnt++ (saturating), first_step<=0, go to WAIT_OBS.
- EP_END (one cycle):
  - episode_cnt++, step_cnt<=0, first_step<=1.
  - Decay: epsilon <= max(epsilon - (epsilon>>EPS_SHIFT), EPS_MIN), using unsigned arithmetic.
  - If episode_cnt+1==num_episodes go to FINISH, else WAIT_OBS.
- FINISH: done=1 for one cycle, busy<=0, go to IDLE. Epsilon and counters hold until the next start.
- epsilon loads eps_init on start without clamping; the floor applies only at decay.
- Latency, observation accepted to act_valid (non-first step): 1+1+UPDATE_LAT+1+policy latency+1 cycles.
- A reset asserted mid-run aborts immediately to the reset values; no partial acc_en or act_valid is produced.

Optional Feature:
QL_POLICY_TIMEOUT_EN:
- Defined: a 6-bit watchdog counts cycles in WAIT_POL. After 64 cycles without pol_done, use action 0, set err=1 (sticky until next accepted start or reset) and go to ISSUE.
- Undefined: no watchdog; WAIT_POL waits indefinitely and err is tied 0.

Decomposition:
- Package ql_sched_pkg holds:
  - FSM state enum;
  - width constants STATE_W, ACTION_W, REWARD_W and EPS_W defaults;
  - EPS_MIN default;
  - watchdog limit 64.
- One sub-module, ql_epsilon_sched, holds the epsilon register. It provides load (start) and decay (EP_END) with floor clamp.

Test Plan:
- start, num_episodes=1, eps_init=0xFFFF; observations s=1, s=2, s=3 (terminal), act_ready always 1:
  - 2 acc_en pulses: (1,a0→2) and (2,a1→3);
  - 2 actions issued;
  - epsilon ends at 0xF000; done pulses once; episode_cnt=1.
- Decay floor: eps_init=0x0110, 2 single-step episodes → epsilon 0x0100 after the first episode, 0x0100 after the second.
- act_ready held low 10 cycles in ISSUE → act_valid and act_out stable throughout; obs_ready=0.
- MAX_STEPS=3, terminal never asserted → EP_END after the 4th observation; step_cnt returns to 0; the next observation produces no acc_en.
- rst_n pulled low in WAIT_LAT → all outputs 0 asynchronously; FSM=IDLE; a new start runs cleanly.
- With QL_POLICY_TIMEOUT_EN, pol_done never asserted → act_out=0 presented 64 cycles after pol_start; err=1.

Source files
------------

// File: rtl/ql_sched_pkg.sv
// Shared types and default constants for the Q-learning step scheduler.
package ql_sched_pkg;

  localparam int unsigned StateW  = 6;
  localparam int unsigned ActionW = 4;
  localparam int unsigned RewardW = 16;
  localparam int unsigned EpsW    = 16;

  localparam logic [15:0] EpsMin  = 16'h0100;

  // Policy watchdog length in cycles (QL_POLICY_TIMEOUT_EN builds only).
  localparam int unsigned WdLimit = 64;

  typedef enum logic [3:0] {
    StIdle,
    StWaitObs,
    StUpdate,
    StWaitLat,
    StPolicy,
    StWaitPol,
    StIssue,
    StEpEnd,
    StFinish
  } sched_state_e;

endpackage

// File: rtl/ql_epsilon_sched.sv
// Epsilon register: loads on run start, decays by eps >> EPS_SHIFT per episode
// with a floor clamp. The initial load is never clamped.
module ql_epsilon_sched #(
  parameter int unsigned      EPS_W     = 16,
  parameter int unsigned      EPS_SHIFT = 4,
  parameter logic [EPS_W-1:0] EPS_MIN   = EPS_W'(16'h0100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             decay_i,
  input  logic [EPS_W-1:0] init_i,
  output logic [EPS_W-1:0] eps_o
);

  logic [EPS_W-1:0] eps_q, eps_d;
  logic [EPS_W-1:0] decayed;

  always_comb begin
    decayed = eps_q - (eps_q >> EPS_SHIFT);
    eps_d   = eps_q;
    if (load_i) begin
      eps_d = init_i;
    end else if (decay_i) begin
      eps_d = (decayed < EPS_MIN) ? EPS_MIN : decayed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eps_q <= '0;
    end else begin
      eps_q <= eps_d;
    end
  end

  assign eps_o = eps_q;

endmodule

// File: rtl/ql_step_scheduler.sv
// Q-learning step sequencer: observation handshake, Q-update strobe, policy request and
// action issue. Define QL_POLICY_TIMEOUT_EN to add the sticky policy watchdog on err.
module ql_step_scheduler
  import ql_sched_pkg::*;
#(
  parameter int unsigned      STATE_W    = StateW,
  parameter int unsigned      ACTION_W   = ActionW,
  parameter int unsigned      REWARD_W   = RewardW,
  parameter int unsigned      EPS_W      = EpsW,
  parameter int unsigned      UPDATE_LAT = 3,
  parameter int unsigned      MAX_STEPS  = 255,
  parameter int unsigned      EPS_SHIFT  = 4,
  parameter logic [EPS_W-1:0] EPS_MIN    = EPS_W'(EpsMin)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         num_episodes,
  input  logic [EPS_W-1:0]    eps_init,
  input  logic                obs_valid,
  output logic                obs_ready,
  input  logic [STATE_W-1:0]  obs_state,
  input  logic [REWARD_W-1:0] obs_reward,
  input  logic                obs_terminal,
  output logic                act_valid,
  input  logic                act_ready,
  output logic [ACTION_W-1:0] act_out,
  output logic                acc_en,
  output logic [STATE_W-1:0]  acc_curr_state,
  output logic [ACTION_W-1:0] acc_curr_action,
  output logic [STATE_W-1:0]  acc_next_state,
  output logic [REWARD_W-1:0] acc_reward,
  output logic                pol_start,
  output logic [STATE_W-1:0]  pol_state,
  input  logic                pol_done,
  input  logic [ACTION_W-1:0] pol_action,
  output logic [EPS_W-1:0]    epsilon,
  output logic                busy,
  output logic                done,
  output logic [15:0]         episode_cnt,
  output logic [7:0]          step_cnt,
  output logic                err
);

  sched_state_e state_q, state_d;

  logic                obs_ready_q, act_valid_q, acc_en_q, pol_start_q, done_q, busy_q;
  logic                first_q, term_q;
  logic [STATE_W-1:0]  cur_state_q, prev_state_q;
  logic [REWARD_W-1:0] cur_reward_q;
  logic [ACTION_W-1:0] act_q, prev_action_q;
  logic [15:0]         num_ep_q, episode_cnt_q;
  logic [7:0]          step_cnt_q, lat_q;
  logic                lat_done, ep_last, max_hit;

`ifdef QL_POLICY_TIMEOUT_EN
  logic [5:0] wd_q;
  logic       err_q;
  logic       wd_expire;
  assign wd_expire = (wd_q == 6'(WdLimit - 1)) && !pol_done;
`endif

  always_comb begin
    lat_done = (32'(lat_q) + 32'd1) >= UPDATE_LAT;
    ep_last  = (episode_cnt_q + 16'd1) == num_ep_q;
    max_hit  = step_cnt_q == 8'(MAX_STEPS);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = (num_episodes == 16'd0) ? StFinish : StWaitObs;
      end
      StWaitObs: begin
        if (obs_valid) begin
          if (!first_q)          state_d = StUpdate;
          else if (obs_terminal) state_d = StEpEnd;
          else                   state_d = StPolicy;
        end
      end
      StUpdate:  state_d = StWaitLat;
      StWaitLat: begin
        if (lat_done) state_d = (term_q || max_hit) ? StEpEnd : StPolicy;
      end
      StPolicy:  state_d = StWaitPol;
      StWaitPol: begin
        if (pol_done) state_d = StIssue;
`ifdef QL_POLICY_TIMEOUT_EN
        else if (wd_expire) state_d = StIssue;
`endif
      end
      StIssue:   if (act_ready) state_d = StWaitObs;
      StEpEnd:   state_d = ep_last ? StFinish : StWaitObs;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered decodes of the next state, so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      obs_ready_q   <= 1'b0;
      act_valid_q   <= 1'b0;
      acc_en_q      <= 1'b0;
      pol_start_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      first_q       <= 1'b1;
      term_q        <= 1'b0;
      cur_state_q   <= '0;
      prev_state_q  <= '0;
      cur_reward_q  <= '0;
      act_q         <= '0;
      prev_action_q <= '0;
      num_ep_q      <= '0;
      episode_cnt_q <= '0;
      step_cnt_q    <= '0;
      lat_q         <= '0;
`ifdef QL_POLICY_TIMEOUT_EN
      wd_q          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      obs_ready_q <= state_d == StWaitObs;
      act_valid_q <= state_d == StIssue;
      acc_en_q    <= state_d == StUpdate;
      pol_start_q <= state_d == StPolicy;
      done_q      <= state_d == StFinish;
      busy_q      <= state_d != StIdle;
      case (state_q)
        StIdle: begin
          if (start) begin
            num_ep_q      <= num_episodes;
            episode_cnt_q <= '0;
            step_cnt_q    <= '0;
            first_q       <= 1'b1;
`ifdef QL_POLICY_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
          end
        end
        StWaitObs: begin
          if (obs_valid) begin
            cur_state_q  <= obs_state;
            cur_reward_q <= obs_reward;
            term_q       <= obs_terminal;
          end
        end
        StUpdate:  lat_q <= '0;
        StWaitLat: lat_q <= lat_q + 8'd1;
`ifdef QL_POLICY_TIMEOUT_EN
        StPolicy:  wd_q <= '0;
        StWaitPol: begin
          wd_q <= wd_q + 6'd1;
          if (pol_done) begin
            act_q <= pol_action;
          end else if (wd_expire) begin
            act_q <= '0;
            err_q <= 1'b1;
          end
        end
`else
        StWaitPol: if (pol_done) act_q <= pol_action;
`endif
        StIssue: begin
          if (act_ready) begin
            prev_state_q  <= cur_state_q;
            prev_action_q <= act_q;
            first_q       <= 1'b0;
            if (step_cnt_q != 8'hFF) step_cnt_q <= step_cnt_q + 8'd1;
          end
        end
        StEpEnd: begin
          episode_cnt_q <= episode_cnt_q + 16'd1;
          step_cnt_q    <= '0;
          first_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  ql_epsilon_sched #(
    .EPS_W     (EPS_W),
    .EPS_SHIFT (EPS_SHIFT),
    .EPS_MIN   (EPS_MIN)
  ) u_eps (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  ((state_q == StIdle) && start),
    .decay_i (state_q == StEpEnd),
    .init_i  (eps_init),
    .eps_o   (epsilon)
  );

  assign obs_ready       = obs_ready_q;
  assign act_valid       = act_valid_q;
  assign act_out         = act_q;
  assign acc_en          = acc_en_q;
  assign acc_curr_state  = prev_state_q;
  assign acc_curr_action = prev_action_q;
  assign acc_next_state  = cur_state_q;
  assign acc_reward      = cur_reward_q;
  assign pol_start       = pol_start_q;
  assign pol_state       = cur_state_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign episode_cnt     = episode_cnt_q;
  assign step_cnt        = step_cnt_q;
`ifdef QL_POLICY_TIMEOUT_EN
  assign err             = err_q;
`else
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_ql_step_scheduler.sv
// Bench for ql_step_scheduler: directed run table, stall/reset/watchdog sequences and
// randomized runs scored against a transaction-level model of an episode.
module tb_ql_step_scheduler;

  localparam int MaxSteps = 3;

  logic        clk, rst_n, start;
  logic [15:0] num_episodes, eps_init;
  logic        obs_valid, obs_ready, obs_terminal;
  logic [5:0]  obs_state;
  logic [15:0] obs_reward;
  logic        act_valid, act_ready;
  logic [3:0]  act_out;
  logic        acc_en;
  logic [5:0]  acc_curr_state, acc_next_state;
  logic [3:0]  acc_curr_action;
  logic [15:0] acc_reward;
  logic        pol_start, pol_done;
  logic [5:0]  pol_state;
  logic [3:0]  pol_action;
  logic [15:0] epsilon, episode_cnt;
  logic        busy, done, err;
  logic [7:0]  step_cnt;

  ql_step_scheduler #(.MAX_STEPS(MaxSteps)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .num_episodes    (num_episodes),
    .eps_init        (eps_init),
    .obs_valid       (obs_valid),
    .obs_ready       (obs_ready),
    .obs_state       (obs_state),
    .obs_reward      (obs_reward),
    .obs_terminal    (obs_terminal),
    .act_valid       (act_valid),
    .act_ready       (act_ready),
    .act_out         (act_out),
    .acc_en          (acc_en),
    .acc_curr_state  (acc_curr_state),
    .acc_curr_action (acc_curr_action),
    .acc_next_state  (acc_next_state),
    .acc_reward      (acc_reward),
    .pol_start       (pol_start),
    .pol_state       (pol_state),
    .pol_done        (pol_done),
    .pol_action      (pol_action),
    .epsilon         (epsilon),
    .busy            (busy),
    .done            (done),
    .episode_cnt     (episode_cnt),
    .step_cnt        (step_cnt),
    .err             (err)
  );

  typedef struct {
    logic [5:0]  s;
    logic [15:0] r;
    logic        t;
  } obs_t;

  typedef struct {
    int          num;
    logic [15:0] eps;
    logic [15:0] mask;
    logic [15:0] x_eps;
    int          x_acc;
    int          x_act;
    int          x_ep;
    int          x_cons;
  } vec_t;

  int tests = 0;
  int fails = 0;

  obs_t        obs_q[$];
  int          obs_idx;
  bit          env_en, act_hold, pol_en;
  logic [3:0]  pol_salt;
  logic [31:0] acc_got[$], exp_acc[$];
  logic [3:0]  act_got[$], exp_act[$];
  int          done_cnt;
  logic [15:0] exp_eps;
  int          exp_ep, exp_cons;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] pol_fn(input logic [5:0] s);
    return s[3:0] ^ {2'b00, s[5:4]} ^ pol_salt;
  endfunction

  // Environment: keeps obs_valid up until accepted, then offers the next queued observation.
  initial begin
    bit hs;
    obs_valid = 1'b0; obs_state = '0; obs_reward = '0; obs_terminal = 1'b0;
    forever begin
      @(negedge clk);
      hs = obs_valid && obs_ready;
      @(posedge clk); #1;
      if (!env_en) begin
        obs_valid = 1'b0;
      end else begin
        if (hs) begin
          obs_idx++;
          obs_valid = 1'b0;
        end
        if (!obs_valid && obs_idx < obs_q.size() && $urandom_range(0, 3) != 0) begin
          obs_state    = obs_q[obs_idx].s;
          obs_reward   = obs_q[obs_idx].r;
          obs_terminal = obs_q[obs_idx].t;
          obs_valid    = 1'b1;
        end
      end
    end
  end

  initial begin
    act_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      act_ready = act_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Policy generator: answers each pol_start after 1..4 cycles with pol_fn(state).
  initial begin
    logic [5:0] s;
    int d;
    pol_done = 1'b0; pol_action = '0;
    forever begin
      @(negedge clk);
      if (pol_start && pol_en && rst_n) begin
        s = pol_state;
        d = $urandom_range(0, 3);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1;
        pol_done = 1'b1; pol_action = pol_fn(s);
        @(posedge clk); #1;
        pol_done = 1'b0; pol_action = 4'($urandom);
      end
    end
  end

  // Monitor: logs updates and accepted actions; checks a stalled action holds still.
  initial begin
    bit pend;
    logic [3:0] pend_act;
    pend = 1'b0; pend_act = '0; done_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) chk("act_hold_stable", {act_valid, act_out}, {1'b1, pend_act});
        if (acc_en) acc_got.push_back({acc_curr_state, acc_curr_action, acc_next_state, acc_reward});
        if (act_valid && act_ready) act_got.push_back(act_out);
        if (done) done_cnt++;
        pend = act_valid && !act_ready;
        pend_act = act_out;
      end
    end
  end

  // Reference: walks the observation list episode by episode.
  task automatic model_run(input int num, input logic [15:0] eps0);
    int ep, step, i;
    bit first;
    logic [5:0] ps;
    logic [3:0] pa, a;
    logic [15:0] e, d;
    exp_acc.delete(); exp_act.delete();
    ep = 0; step = 0; i = 0; first = 1'b1; e = eps0; ps = '0; pa = '0;
    while (ep < num && i < obs_q.size()) begin
      obs_t o;
      o = obs_q[i];
      i++;
      if (!first) exp_acc.push_back({ps, pa, o.s, o.r});
      if (first ? o.t : (o.t || step == MaxSteps)) begin
        ep++; step = 0; first = 1'b1;
        d = e - (e >> 4);
        e = (d < 16'h0100) ? 16'h0100 : d;
      end else begin
        a = pol_fn(o.s);
        exp_act.push_back(a);
        ps = o.s; pa = a; first = 1'b0;
        if (step < 255) step++;
      end
    end
    exp_eps = e; exp_ep = ep; exp_cons = i;
  endtask

  task automatic start_run(input int num, input logic [15:0] eps);
    env_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs_idx = 0;
    acc_got.delete(); act_got.delete(); done_cnt = 0;
    num_episodes = 16'(num); eps_init = eps; start = 1'b1;
    env_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_episodes = 16'hDEAD; eps_init = 16'hBEEF;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    env_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (done_cnt != 0);
    if (!ok) begin
      chk("done_timeout", 64'd0, 64'd1);
      reset_dut();
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_acc_count"}, 64'(acc_got.size()), 64'(exp_acc.size()));
    for (int i = 0; i < acc_got.size() && i < exp_acc.size(); i++)
      chk({tag, "_acc_entry"}, 64'(acc_got[i]), 64'(exp_acc[i]));
    chk({tag, "_act_count"}, 64'(act_got.size()), 64'(exp_act.size()));
    for (int i = 0; i < act_got.size() && i < exp_act.size(); i++)
      chk({tag, "_act_entry"}, 64'(act_got[i]), 64'(exp_act[i]));
    chk({tag, "_epsilon"}, 64'(epsilon), 64'(exp_eps));
    chk({tag, "_episode_cnt"}, 64'(episode_cnt), 64'(exp_ep));
    chk({tag, "_obs_consumed"}, 64'(obs_idx), 64'(exp_cons));
    chk({tag, "_idle_flags"}, {61'd0, busy, step_cnt == 8'd0, err}, 64'b010);
  endtask

  task automatic build_mask(input logic [15:0] mask);
    obs_t o;
    obs_q.delete();
    for (int i = 0; i < 16; i++) begin
      o.s = 6'(i + 1);
      o.r = 16'(i * 1000 - 3000);
      o.t = mask[i];
      obs_q.push_back(o);
    end
  endtask

  task automatic do_run(input string tag, input int num, input logic [15:0] eps);
    bit ok;
    model_run(num, eps);
    start_run(num, eps);
    wait_done(ok);
    if (ok) check_run(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {47'd0, obs_ready, act_valid, act_out, acc_en, pol_start, pol_state,
                         busy, done, err}, 64'd0);
    chk({tag, "_acc"}, {32'd0, acc_curr_state, acc_curr_action, acc_next_state, acc_reward},
        64'd0);
    chk({tag, "_cnt"}, {24'd0, epsilon, episode_cnt, step_cnt}, 64'd0);
  endtask

  initial begin
    vec_t tbl[6];
    bit ok;
    int n;
    logic [3:0] held;
    obs_t o;

    tbl[0] = '{1, 16'hFFFF, 16'h0004, 16'hF000, 2, 2, 1, 3};
    tbl[1] = '{1, 16'h0110, 16'h0001, 16'h0100, 0, 0, 1, 1};
    tbl[2] = '{2, 16'h0110, 16'h0003, 16'h0100, 0, 0, 2, 2};
    tbl[3] = '{2, 16'h8000, 16'h0010, 16'h7080, 3, 3, 2, 5};
    tbl[4] = '{0, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 0};
    tbl[5] = '{3, 16'hFFFF, 16'h0016, 16'hD2F0, 2, 2, 3, 5};

    rst_n = 1'b0; start = 1'b0; num_episodes = '0; eps_init = '0;
    env_en = 1'b0; act_hold = 1'b0; pol_en = 1'b1; pol_salt = 4'h5; obs_idx = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      pol_salt = 4'(k * 3 + 1);
      build_mask(tbl[k].mask);
      do_run($sformatf("vec%0d", k), tbl[k].num, tbl[k].eps);
      chk($sformatf("vec%0d_eps_const", k), 64'(epsilon), 64'(tbl[k].x_eps));
      chk($sformatf("vec%0d_counts", k),
          {16'(acc_got.size()), 16'(act_got.size()), 16'(episode_cnt), 16'(obs_idx)},
          {16'(tbl[k].x_acc), 16'(tbl[k].x_act), 16'(tbl[k].x_ep), 16'(tbl[k].x_cons)});
    end

    // Action stalled in ISSUE for 10 cycles.
    build_mask(16'h0004);
    pol_salt = 4'hA;
    model_run(1, 16'hFFFF);
    act_hold = 1'b1;
    start_run(1, 16'hFFFF);
    n = 0;
    while (!act_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_issue", 64'(act_valid), 64'd1);
    held = act_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {58'd0, act_valid, obs_ready, act_out}, {58'd0, 2'b10, held});
    end
    act_hold = 1'b0;
    wait_done(ok);
    if (ok) check_run("stall");

    // Asynchronous reset while waiting on the update latency.
    build_mask(16'h0000);
    start_run(1, 16'h4000);
    n = 0;
    while (!acc_en && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_update", 64'(acc_en), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("midrun_reset");
    env_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", {62'd0, busy, obs_ready}, 64'd0);
    build_mask(tbl[0].mask);
    pol_salt = 4'h3;
    do_run("after_reset", 1, 16'hFFFF);

`ifdef QL_POLICY_TIMEOUT_EN
    build_mask(16'h0002);
    pol_en = 1'b0;
    start_run(1, 16'h8000);
    n = 0;
    while (!pol_start && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wd_pol_start", 64'(pol_start), 64'd1);
    n = 0;
    while (!act_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wd_latency", 64'(n == 64 || n == 65), 64'd1);
    chk("wd_action_err", {59'd0, act_valid, act_out, err}, {59'd0, 1'b1, 4'h0, 1'b1});
    pol_en = 1'b1;
    wait_done(ok);
    chk("wd_err_sticky", 64'(err), 64'd1);
    build_mask(tbl[0].mask);
    do_run("wd_clear", 1, 16'hFFFF);
`endif

    for (int r = 0; r < 25; r++) begin
      int num;
      logic [15:0] eps;
      obs_q.delete();
      for (int i = 0; i < 24; i++) begin
        o.s = 6'($urandom);
        o.r = 16'($urandom);
        o.t = ($urandom_range(0, 3) == 0);
        obs_q.push_back(o);
      end
      pol_salt = 4'($urandom);
      num = $urandom_range(0, 4);
      eps = 16'($urandom);
      do_run($sformatf("rand%0d", r), num, eps);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
